// File: rtl/dlsc_dcm_clkgen_pkg.sv
// Shared definitions for the DCM clock generator: register word map, flag/status bit positions
// and the reprogramming sequencer state encoding.
package dlsc_dcm_clkgen_pkg;

    localparam logic [3:0] REG_CONTROL    = 4'd0;
    localparam logic [3:0] REG_STATUS     = 4'd1;
    localparam logic [3:0] REG_INT_FLAGS  = 4'd2;
    localparam logic [3:0] REG_INT_SELECT = 4'd3;
    localparam logic [3:0] REG_MULTIPLY   = 4'd4;
    localparam logic [3:0] REG_DIVIDE     = 4'd5;

    localparam int STATUS_ACTIVE_BIT = 0;
    localparam int INT_ENABLED_BIT   = 0;
    localparam int INT_DISABLED_BIT  = 1;

    localparam logic [31:0] INT_ENABLED_MASK  = 32'h1 << INT_ENABLED_BIT;
    localparam logic [31:0] INT_DISABLED_MASK = 32'h1 << INT_DISABLED_BIT;

    typedef enum logic [3:0] {
        ST_INIT, ST_IDLE, ST_RD_STATUS, ST_DIS_WR, ST_DIS_WAIT, ST_DIS_CLR,
        ST_WR_MUL, ST_WR_DIV, ST_EN_WR, ST_EN_WAIT, ST_EN_CLR, ST_DONE
    } state_t;

    function automatic logic [31:0] word_addr(input logic [3:0] idx);
        return {26'd0, idx, 2'b00};
    endfunction

    // States that own exactly one APB transfer
    function automatic logic is_xfer_state(input state_t s);
        return s inside {ST_INIT, ST_RD_STATUS, ST_DIS_WR, ST_DIS_CLR,
                         ST_WR_MUL, ST_WR_DIV, ST_EN_WR, ST_EN_CLR};
    endfunction

endpackage

// File: rtl/dlsc_apb_master_xfer.sv
// Single-transfer APB master engine: one SETUP cycle then ACCESS until ready. A new start may be
// accepted on the completing cycle so back-to-back transfers have no idle cycle between them.
module dlsc_apb_master_xfer #(
    parameter int ADDR = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ADDR-1:0] addr,
    input  logic [31:0]     wdata,
    input  logic            write,
    output logic            busy,
    output logic            done,
    output logic [31:0]     rdata,
    output logic            slverr,
    output logic [ADDR-1:0] apb_addr,
    output logic            apb_sel,
    output logic            apb_enable,
    output logic            apb_write,
    output logic [31:0]     apb_wdata,
    output logic [3:0]      apb_strb,
    input  logic            apb_ready,
    input  logic [31:0]     apb_rdata,
    input  logic            apb_slverr
);

    assign done   = apb_sel & apb_enable & apb_ready;
    assign slverr = done & apb_slverr;
    assign rdata  = apb_rdata;
    assign busy   = apb_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apb_sel    <= 1'b0;
            apb_enable <= 1'b0;
            apb_write  <= 1'b0;
            apb_addr   <= '0;
            apb_wdata  <= '0;
            apb_strb   <= 4'h0;
        end else if (start && (!apb_sel || done)) begin
            apb_sel    <= 1'b1;
            apb_enable <= 1'b0;
            apb_write  <= write;
            apb_addr   <= addr;
            apb_wdata  <= write ? wdata : 32'd0;
            apb_strb   <= write ? 4'hF : 4'h0;
        end else if (apb_sel && !apb_enable) begin
            apb_enable <= 1'b1;
        end else if (done) begin
            // Bus returns to all-zero when no transfer follows
            apb_sel    <= 1'b0;
            apb_enable <= 1'b0;
            apb_write  <= 1'b0;
            apb_addr   <= '0;
            apb_wdata  <= '0;
            apb_strb   <= 4'h0;
        end
    end

endmodule

// File: rtl/dlsc_dcm_clkgen_prog.sv
// Autonomous APB sequencer that disables, reprograms and re-enables the DCM clock generator.
// Optional DLSC_DCM_CLKGEN_PROG_TIMEOUT_EN bounds the interrupt waits to TIMEOUT cycles.
module dlsc_dcm_clkgen_prog
    import dlsc_dcm_clkgen_pkg::*;
#(
    parameter int ADDR    = 32,
    parameter int MD_BITS = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic               apb_clk,
    input  logic               apb_rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MD_BITS-1:0] cfg_multiply,
    input  logic [MD_BITS-1:0] cfg_divide,
    input  logic               cfg_disable,
    output logic               done,
    output logic               err,
    output logic               busy,
    output logic [ADDR-1:0]    apb_addr,
    output logic               apb_sel,
    output logic               apb_enable,
    output logic               apb_write,
    output logic [31:0]        apb_wdata,
    output logic [3:0]         apb_strb,
    input  logic               apb_ready,
    input  logic [31:0]        apb_rdata,
    input  logic               apb_slverr,
    input  logic               int_in
);

    state_t             state_reg, state_next;
    logic [MD_BITS-1:0] mul_reg, div_reg;
    logic               dis_reg;
    logic               xfer_start, xfer_write, xfer_busy, xfer_done, xfer_slverr;
    logic [ADDR-1:0]    xfer_addr;
    logic [31:0]        xfer_wdata, xfer_rdata;
    logic               wait_timeout, abort;
    logic               cfg_ready_next, done_next, err_next, busy_next;
    logic               unused_rdata;

    assign unused_rdata = ^xfer_rdata;

`ifdef DLSC_DCM_CLKGEN_PROG_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt_reg;

    // Counter restarts at zero on every entry into a wait state
    always_ff @(posedge apb_clk or posedge apb_rst) begin
        if (apb_rst)
            wait_cnt_reg <= '0;
        else if (state_reg != ST_DIS_WAIT && state_reg != ST_EN_WAIT)
            wait_cnt_reg <= '0;
        else
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
    assign wait_timeout = (wait_cnt_reg == CW'(TIMEOUT - 1));
`else
    localparam int unused_timeout = TIMEOUT;
    assign wait_timeout = 1'b0;
`endif

    always_ff @(posedge apb_clk or posedge apb_rst) begin
        if (apb_rst) begin
            state_reg <= ST_INIT;
            cfg_ready <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            mul_reg   <= '0;
            div_reg   <= '0;
            dis_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cfg_ready <= cfg_ready_next;
            done      <= done_next;
            err       <= err_next;
            busy      <= busy_next;
            if (state_reg == ST_IDLE && cfg_valid) begin
                mul_reg <= cfg_multiply;
                div_reg <= cfg_divide;
                dis_reg <= cfg_disable;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        abort      = 1'b0;
        case (state_reg)
            ST_INIT:      if (xfer_done) state_next = ST_IDLE;
            ST_IDLE:      if (cfg_valid) state_next = ST_RD_STATUS;
            ST_RD_STATUS: if (xfer_done) begin
                              if (xfer_rdata[STATUS_ACTIVE_BIT]) state_next = ST_DIS_WR;
                              else if (dis_reg)                  state_next = ST_DONE;
                              else                               state_next = ST_WR_MUL;
                          end
            ST_DIS_WR:    if (xfer_done) state_next = ST_DIS_WAIT;
            ST_DIS_WAIT:  if (int_in) state_next = ST_DIS_CLR;
                          else if (wait_timeout) begin state_next = ST_DONE; abort = 1'b1; end
            ST_DIS_CLR:   if (xfer_done) state_next = dis_reg ? ST_DONE : ST_WR_MUL;
            ST_WR_MUL:    if (xfer_done) state_next = ST_WR_DIV;
            ST_WR_DIV:    if (xfer_done) state_next = ST_EN_WR;
            ST_EN_WR:     if (xfer_done) state_next = ST_EN_WAIT;
            ST_EN_WAIT:   if (int_in) state_next = ST_EN_CLR;
                          else if (wait_timeout) begin state_next = ST_DONE; abort = 1'b1; end
            ST_EN_CLR:    if (xfer_done) state_next = ST_DONE;
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_INIT;
        endcase
        // A slave error aborts the sequence, except during INIT which always falls through to IDLE
        if (xfer_slverr && state_reg != ST_INIT)
            state_next = ST_DONE;
    end

    always_comb begin
        xfer_start = is_xfer_state(state_next) && (state_next != state_reg || !xfer_busy);
        xfer_write = 1'b1;
        xfer_addr  = ADDR'(word_addr(REG_CONTROL));
        xfer_wdata = 32'd0;
        case (state_next)
            ST_INIT:      begin xfer_addr = ADDR'(word_addr(REG_INT_SELECT));
                                xfer_wdata = INT_ENABLED_MASK | INT_DISABLED_MASK; end
            ST_RD_STATUS: begin xfer_addr = ADDR'(word_addr(REG_STATUS)); xfer_write = 1'b0; end
            ST_DIS_WR:    xfer_wdata = 32'd0;
            ST_DIS_CLR:   begin xfer_addr = ADDR'(word_addr(REG_INT_FLAGS)); xfer_wdata = INT_DISABLED_MASK; end
            ST_WR_MUL:    begin xfer_addr = ADDR'(word_addr(REG_MULTIPLY)); xfer_wdata = 32'(mul_reg); end
            ST_WR_DIV:    begin xfer_addr = ADDR'(word_addr(REG_DIVIDE)); xfer_wdata = 32'(div_reg); end
            ST_EN_WR:     xfer_wdata = 32'd1;
            ST_EN_CLR:    begin xfer_addr = ADDR'(word_addr(REG_INT_FLAGS)); xfer_wdata = INT_ENABLED_MASK; end
            default:      ;
        endcase
        cfg_ready_next = (state_next == ST_IDLE);
        done_next      = (state_next == ST_DONE);
        busy_next      = !(state_next inside {ST_INIT, ST_IDLE, ST_DONE});
        err_next       = xfer_slverr || abort;
    end

    dlsc_apb_master_xfer #(.ADDR(ADDR)) u_xfer (
        .clk        (apb_clk),
        .rst        (apb_rst),
        .start      (xfer_start),
        .addr       (xfer_addr),
        .wdata      (xfer_wdata),
        .write      (xfer_write),
        .busy       (xfer_busy),
        .done       (xfer_done),
        .rdata      (xfer_rdata),
        .slverr     (xfer_slverr),
        .apb_addr   (apb_addr),
        .apb_sel    (apb_sel),
        .apb_enable (apb_enable),
        .apb_write  (apb_write),
        .apb_wdata  (apb_wdata),
        .apb_strb   (apb_strb),
        .apb_ready  (apb_ready),
        .apb_rdata  (apb_rdata),
        .apb_slverr (apb_slverr)
    );

endmodule

// File: tb/tb_dlsc_dcm_clkgen_prog.sv
// Directed bench for dlsc_dcm_clkgen_prog: APB slave model with a transfer scoreboard, interrupt
// model driven by CONTROL writes; timeout checks compiled in with DLSC_DCM_CLKGEN_PROG_TIMEOUT_EN.
module tb_dlsc_dcm_clkgen_prog;

    logic        clk = 1'b0;
    logic        apb_rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  cfg_multiply = 8'd0;
    logic [7:0]  cfg_divide = 8'd0;
    logic        cfg_disable = 1'b0;
    logic        done, err, busy;
    logic [31:0] apb_addr;
    logic        apb_sel, apb_enable, apb_write;
    logic [31:0] apb_wdata;
    logic [3:0]  apb_strb;
    logic        apb_ready = 1'b0;
    logic [31:0] apb_rdata = 32'd0;
    logic        apb_slverr = 1'b0;
    logic        int_in = 1'b0;

    dlsc_dcm_clkgen_prog #(.ADDR(32), .MD_BITS(8), .TIMEOUT(100)) dut (
        .apb_clk(clk), .apb_rst(apb_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_multiply(cfg_multiply), .cfg_divide(cfg_divide), .cfg_disable(cfg_disable),
        .done(done), .err(err), .busy(busy), .apb_addr(apb_addr), .apb_sel(apb_sel),
        .apb_enable(apb_enable), .apb_write(apb_write), .apb_wdata(apb_wdata),
        .apb_strb(apb_strb), .apb_ready(apb_ready), .apb_rdata(apb_rdata),
        .apb_slverr(apb_slverr), .int_in(int_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t exp_q[$];
    int    checks = 0;
    int    fails = 0;
    int    cyc = 0;
    int    ws = 0;
    logic  [31:0] status_val = 32'd0;
    logic  err_inject = 1'b0;
    logic  [31:0] err_addr = 32'd0;
    logic  int_en = 1'b1;
    int    int_n = 5;
    int    int_at = 1000000;
    int    en_cyc = 0;
    int    acc_cnt = 0;
    logic  [68:0] su_vals = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic w, input logic [31:0] d);
        xfer_t e;
        e.addr = a; e.write = w; e.wdata = d;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) cyc++;

    // APB slave model and scoreboard; the cycle where ready is raised is the completing cycle
    always @(negedge clk) begin
        if (apb_rst) begin
            apb_ready = 1'b0; apb_slverr = 1'b0; acc_cnt = 0;
        end else if (apb_sel && apb_enable) begin
            chk("hold_stable", {apb_addr, apb_write, apb_wdata, apb_strb}, su_vals);
            if (acc_cnt >= ws) begin
                xfer_t e;
                apb_ready  = 1'b1;
                apb_rdata  = (apb_addr == 32'h4) ? status_val : 32'd0;
                apb_slverr = err_inject && (apb_addr == err_addr);
                chk("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("xfer_addr", apb_addr, e.addr);
                    chk("xfer_write", apb_write, e.write);
                    chk("xfer_strb", apb_strb, e.write ? 4'hF : 4'h0);
                    if (e.write) chk("xfer_wdata", apb_wdata, e.wdata);
                end
                if (apb_write && apb_addr == 32'h0) begin
                    int_at = cyc + int_n;
                    if (apb_wdata == 32'd1) en_cyc = cyc + 1;
                end
                if (apb_write && apb_addr == 32'h8) int_at = 1000000;
            end else begin
                apb_ready = 1'b0; apb_slverr = 1'b0;
            end
            acc_cnt++;
        end else begin
            if (apb_sel) su_vals = {apb_addr, apb_write, apb_wdata, apb_strb};
            apb_ready = 1'b0; apb_slverr = 1'b0; acc_cnt = 0;
        end
        int_in = int_en && (cyc >= int_at);
    end

    task automatic wait_ready(input int bound);
        int n = 0;
        while (!cfg_ready && n < bound) begin @(negedge clk); n++; end
        chk("ready_timeout", cfg_ready, 1'b1);
    endtask

    task automatic issue(input logic [7:0] m, input logic [7:0] d, input logic dis, output int acc);
        wait_ready(200);
        cfg_multiply = m; cfg_divide = d; cfg_disable = dis; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        acc = cyc;
        chk("ready_drop", cfg_ready, 1'b0);
        chk("busy_set", busy, 1'b1);
    endtask

    task automatic wait_done(input int bound, output int dcyc, output logic e);
        int n = 0;
        while (!done && n < bound) begin @(negedge clk); n++; end
        chk("done_timeout", done, 1'b1);
        dcyc = cyc;
        e = err;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        apb_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, apb_strb,
                              cfg_ready, done, err, busy}, '0);
        push(32'h0C, 1'b1, 32'h3);
        apb_rst = 1'b0;
        wait_ready(50);
        chk("init_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("idle_outputs", {apb_sel, apb_enable, apb_write, apb_addr, apb_wdata, apb_strb,
                             done, err, busy}, '0);
    endtask

    initial begin
        int   acc, dcyc;
        logic e;

        // Reset and INIT sequence
        reset_dut();

        // Program with clock inactive, interrupt 20 cycles after enable
        ws = 0; status_val = 32'd0; int_n = 20;
        push(32'h04, 1'b0, 32'd0); push(32'h10, 1'b1, 32'd56); push(32'h14, 1'b1, 32'd42);
        push(32'h00, 1'b1, 32'd1); push(32'h08, 1'b1, 32'd1);
        issue(8'd56, 8'd42, 1'b0, acc);
        wait_done(200, dcyc, e);
        chk("prog_latency", 32'(dcyc - acc), 32'd30);
        chk("prog_err", e, 1'b0);
        chk("prog_queue", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("prog_busy_clear", {busy, done}, 2'b00);

        // Clock active: disable first
        status_val = 32'd1; int_n = 4;
        push(32'h04, 1'b0, 32'd0); push(32'h00, 1'b1, 32'd0); push(32'h08, 1'b1, 32'd2);
        push(32'h10, 1'b1, 32'd56); push(32'h14, 1'b1, 32'd42);
        push(32'h00, 1'b1, 32'd1); push(32'h08, 1'b1, 32'd1);
        issue(8'd56, 8'd42, 1'b0, acc);
        wait_done(200, dcyc, e);
        chk("active_err", e, 1'b0);
        chk("active_queue", 32'(exp_q.size()), 32'd0);

        // Disable-only, clock active
        int_n = 1;
        push(32'h04, 1'b0, 32'd0); push(32'h00, 1'b1, 32'd0); push(32'h08, 1'b1, 32'd2);
        issue(8'd9, 8'd7, 1'b1, acc);
        wait_done(200, dcyc, e);
        chk("dis_err", e, 1'b0);
        chk("dis_queue", 32'(exp_q.size()), 32'd0);

        // Disable-only, clock already inactive
        status_val = 32'd0;
        push(32'h04, 1'b0, 32'd0);
        issue(8'd9, 8'd7, 1'b1, acc);
        wait_done(200, dcyc, e);
        chk("dis_idle_err", e, 1'b0);
        chk("dis_idle_queue", 32'(exp_q.size()), 32'd0);

        // Slave error on DIVIDE write with 3 wait states per transfer
        ws = 3; err_inject = 1'b1; err_addr = 32'h14;
        push(32'h04, 1'b0, 32'd0); push(32'h10, 1'b1, 32'd3); push(32'h14, 1'b1, 32'd5);
        issue(8'd3, 8'd5, 1'b0, acc);
        wait_done(200, dcyc, e);
        chk("slverr_err", {done, e}, 2'b11);
        chk("slverr_busy_drop", busy, 1'b0);
        @(negedge clk);
        chk("slverr_ready_back", {cfg_ready, done, err}, 3'b100);
        repeat (5) @(negedge clk);
        chk("slverr_queue", 32'(exp_q.size()), 32'd0);
        err_inject = 1'b0; ws = 0;

`ifdef DLSC_DCM_CLKGEN_PROG_TIMEOUT_EN
        // Interrupt never arrives: err after TIMEOUT cycles, no flag clear
        int_en = 1'b0;
        push(32'h04, 1'b0, 32'd0); push(32'h10, 1'b1, 32'd11); push(32'h14, 1'b1, 32'd12);
        push(32'h00, 1'b1, 32'd1);
        issue(8'd11, 8'd12, 1'b0, acc);
        wait_done(300, dcyc, e);
        chk("timeout_err", e, 1'b1);
        chk("timeout_cycles", 32'(dcyc - en_cyc), 32'd100);
        chk("timeout_queue", 32'(exp_q.size()), 32'd0);
        int_en = 1'b1;
`endif

        // Hang in EN_WAIT, then reset mid-sequence reruns INIT
        int_en = 1'b0;
        push(32'h04, 1'b0, 32'd0); push(32'h10, 1'b1, 32'd21); push(32'h14, 1'b1, 32'd22);
        push(32'h00, 1'b1, 32'd1);
        issue(8'd21, 8'd22, 1'b0, acc);
        repeat (60) @(negedge clk);
        chk("hang_busy", {busy, done, apb_sel}, 3'b100);
        chk("hang_queue", 32'(exp_q.size()), 32'd0);
        int_en = 1'b1;
        reset_dut();

        // Recovery run with one wait state
        ws = 1; int_n = 2;
        push(32'h04, 1'b0, 32'd0); push(32'h10, 1'b1, 32'd255); push(32'h14, 1'b1, 32'd0);
        push(32'h00, 1'b1, 32'd1); push(32'h08, 1'b1, 32'd1);
        issue(8'd255, 8'd0, 1'b0, acc);
        wait_done(200, dcyc, e);
        chk("recover_err", e, 1'b0);
        chk("recover_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dlsc_dcm_clkgen_prog.md
# dlsc_dcm_clkgen_prog

APB master sequencer that sits directly upstream of the DCM clock generator's APB register port and reprograms it autonomously. Accepts a multiply/divide (or disable) request on a valid/ready interface, then performs the full disable → program → enable → interrupt-acknowledge sequence, reporting completion or error. Lets a controller retune the generated clock without running software APB sequences.

## Interface
- ADDR, 32: APB byte-address width.
- MD_BITS, 8: width of multiply/divide fields (register value = ratio − 1).
- TIMEOUT, 65535: max apb_clk cycles waiting on int_in (used only with timeout macro).

- apb_clk  in  1  clock; all logic in this single domain.
- apb_rst  in  1  reset; asynchronous, active-high.
- cfg_valid  in  1  request valid.
- cfg_ready  out  1  request accepted when valid & ready.
- cfg_multiply  in  MD_BITS  value written to MULTIPLY.
- cfg_divide  in  MD_BITS  value written to DIVIDE.
- cfg_disable  in  1  1 = disable only, no reprogram/enable.
- done  out  1  one-cycle pulse at sequence end.
- err  out  1  one-cycle pulse coincident with done on failure.
- busy  out  1  high from acceptance until done.
- apb_addr  out  ADDR  byte address (word index << 2).
- apb_sel, apb_enable, apb_write  out  1  APB control.
- apb_wdata  out  32  write data.
- apb_strb  out  4  4'hF on writes, 4'h0 on reads.
- apb_ready  in  1  slave ready.
- apb_rdata  in  32  read data.
- apb_slverr  in  1  slave error.
- int_in  in  1  clkgen interrupt, level, synchronous to apb_clk.

## Operation
- Target word indices: CONTROL 0, STATUS 1, INT_FLAGS 2, INT_SELECT 3, MULTIPLY 4, DIVIDE 5. STATUS bit0 = output active. INT_FLAGS bit0 = enabled, bit1 = disabled (write-1-to-clear).
- States: INIT, IDLE, RD_STATUS, DIS_WR, DIS_WAIT, DIS_CLR, WR_MUL, WR_DIV, EN_WR, EN_WAIT, EN_CLR, DONE.
- INIT: after reset, write INT_SELECT=0x3 once, then IDLE. cfg_ready=1 only in IDLE.
- Accept: latch cfg fields, busy=1, go RD_STATUS.
- RD_STATUS: STATUS bit0=1 → DIS_WR; else → WR_MUL (or DONE if cfg_disable).
- DIS_WR: CONTROL=0; DIS_WAIT until int_in=1; DIS_CLR: INT_FLAGS=0x2; then WR_MUL, or DONE if cfg_disable.
- WR_MUL/WR_DIV: write zero-extended latched values; EN_WR: CONTROL=1; EN_WAIT until int_in; EN_CLR: INT_FLAGS=0x1; DONE.
- DONE: done pulse one cycle, busy drops same edge, → IDLE.
- apb_slverr=1 on any completing transfer: abort immediately to DONE with err=1. Slverr during INIT: err pulse, still enter IDLE.

## Timing
- Reset values: all APB outputs 0, cfg_ready/done/err/busy 0; state INIT.
- All outputs registered. Transfer: SETUP (sel=1, enable=0) one cycle, ACCESS (sel=1, enable=1) until apb_ready=1. Addr/write/wdata/strb stable across SETUP+ACCESS.
- Next transfer's SETUP starts the cycle after ACCESS completes; no idle cycle. sel drops only when entering a wait state, IDLE or DONE.
- int_in sampled one cycle after the preceding write's ACCESS completes; int_in already high then proceeds immediately.
- Zero-wait slave, STATUS=0, int_in asserted N cycles after EN_WR: acceptance → done = 10 + N cycles.
- apb_rst mid-sequence: bus abandoned, return to INIT; clkgen state unknown, INIT re-runs.

## Configuration
- DLSC_DCM_CLKGEN_PROG_TIMEOUT_EN defined: DIS_WAIT/EN_WAIT counters; int_in still low after TIMEOUT cycles → DONE with err=1, no flag clear. Counter clears on entering each wait state.
- Undefined: no counter; waits indefinitely, err only from slverr.

## Structure
- Shared package dlsc_dcm_clkgen_pkg: register word indices, INT_FLAGS/STATUS bit positions, state encoding.
- One sub-module: dlsc_apb_master_xfer (single-transfer SETUP/ACCESS engine with start/addr/wdata/write in, done/rdata/slverr out); FSM in top.

## Test plan
- Reset then release → one write 0x0C=0x3, then cfg_ready=1, all other outputs 0.
- multiply=56, divide=42, STATUS=0, int_in 20 cycles after CONTROL write → writes 0x10=56, 0x14=42, 0x00=1, 0x08=1; done with err=0 at 30 cycles.
- Same request, STATUS=1 → 0x00=0, wait int, 0x08=2 precede programming sequence.
- cfg_disable=1, STATUS=1 → only read, 0x00=0, 0x08=2; done, no MULTIPLY/DIVIDE writes.
- apb_slverr on 0x14 write → done+err same cycle, no further transfers, cfg_ready back next cycle; 3 apb_ready wait states on any transfer → signals held stable.
- Macro on, TIMEOUT=100, int_in never asserts → err pulse 100 cycles after EN_WR completes; macro off → busy stays high.
